// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative SLL/SRL/SRA.
// Result and zero are registered and held until the consumer takes them.
module alu_iter_exec #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the result
    // stays stable until out_ready is seen. Neither ready depends on the other valid.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW:0] STEP_MAX = (CW + 1)'(SHIFT_STEP);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_SRA = 2'd2
    } kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d, kind_in;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [CW-1:0]    shamt;
    logic             is_shift;
    logic [WIDTH-1:0] alu_res;
    logic [CW:0]      step;
    logic             last_step;
    logic [WIDTH-1:0] acc_shifted;

    assign shamt = op_b[CW-1:0];

    // Shifts never use the full barrel here: only shamt==0 completes in one cycle.
    always_comb begin
        alu_res  = op_a + op_b;
        is_shift = 1'b0;
        kind_in  = K_SLL;
        case (ALUctl)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_SLL: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_in  = K_SLL;
            end
            ALU_SRL: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_in  = K_SRL;
            end
            ALU_SRA: begin
                alu_res  = op_a;
                is_shift = 1'b1;
                kind_in  = K_SRA;
            end
            default:  alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        last_step = ({1'b0, cnt_q} <= STEP_MAX);
        step      = last_step ? {1'b0, cnt_q} : STEP_MAX;
        case (kind_q)
            K_SRL:   acc_shifted = acc_q >> step;
            K_SRA:   acc_shifted = $unsigned($signed(acc_q) >>> step);
            default: acc_shifted = acc_q << step;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = op_a;
                        cnt_d   = shamt;
                        kind_d  = kind_in;
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_shifted;
                // When not the last step, step < cnt < WIDTH so it fits in CW bits.
                cnt_d = last_step ? '0 : (cnt_q - step[CW-1:0]);
                if (last_step) begin
                    result_d = acc_shifted;
                    zero_d   = (acc_shifted == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            zero_d   = zero_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= K_SLL;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Bench for alu_iter_exec: vector table with scoreboard queue, plus directed
// sequences for stalls, flush, reset and a SHIFT_STEP=4 instance.
module tb_alu_iter_exec;
    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b1000;
    localparam logic [3:0] C_SLL  = 4'b0001;
    localparam logic [3:0] C_SLT  = 4'b0010;
    localparam logic [3:0] C_SLTU = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SRA  = 4'b1101;
    localparam logic [3:0] C_OR   = 4'b0110;
    localparam logic [3:0] C_AND  = 4'b0111;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_valid4, out_ready;
    logic [3:0]  ALUctl;
    logic [31:0] op_a, op_b;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;
    logic [1:0]  dbg_state;
    logic        in_ready4, out_valid4, zero4, busy4;
    logic [31:0] result4;
    logic [1:0]  dbg_state4;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    alu_iter_exec #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUctl(ALUctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy),
        .dbg_state(dbg_state)
    );

    alu_iter_exec #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
        .ALUctl(ALUctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid4),
        .out_ready(out_ready), .result(result4), .zero(zero4), .busy(busy4),
        .dbg_state(dbg_state4)
    );

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  sh;
        sh = b[4:0];
        case (c)
            C_SUB:   r = a - b;
            C_SLL:   r = a << sh;
            C_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            C_XOR:   r = a ^ b;
            C_SRL:   r = a >> sh;
            C_SRA:   r = $unsigned($signed(a) >>> sh);
            C_OR:    r = a | b;
            C_AND:   r = a & b;
            default: r = a + b;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [31:0] b, input int step);
        int n;
        n = int'(b[4:0]);
        if ((c == C_SLL || c == C_SRL || c == C_SRA) && n != 0) return 1 + (n + step - 1) / step;
        return 1;
    endfunction

    // Drives one op into the SHIFT_STEP=1 instance, then waits for and checks its result.
    task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input int el);
        int          lat;
        bit          got;
        logic [32:0] e;
        int          elat;
        @(negedge clk);
        check({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        ALUctl   = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        exp_q.push_back({ez, er});
        lat_q.push_back(el);
        @(posedge clk);
        lat = 0;
        got = 0;
        while (lat < 200 && !got) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) got = 1;
        end
        e    = exp_q.pop_front();
        elat = lat_q.pop_front();
        if (!got) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({nm, "_result"}, {32'd0, result}, {32'd0, e[31:0]});
            check({nm, "_zero"}, {63'd0, zero}, {63'd0, e[32]});
            check({nm, "_latency"}, 64'(lat), 64'(elat));
        end
        @(posedge clk);
        @(negedge clk);
        check({nm, "_idle_after"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    task automatic run_op4(input string nm, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input int el);
        int lat;
        bit got;
        @(negedge clk);
        ALUctl    = c;
        op_a      = a;
        op_b      = b;
        in_valid4 = 1'b1;
        @(posedge clk);
        lat = 0;
        got = 0;
        while (lat < 100 && !got) begin
            @(negedge clk);
            in_valid4 = 1'b0;
            lat++;
            if (out_valid4) got = 1;
        end
        if (!got) check({nm, "_timeout"}, 64'd0, 64'd1);
        else begin
            check({nm, "_result"}, {32'd0, result4}, {32'd0, er});
            check({nm, "_latency"}, 64'(lat), 64'(el));
        end
        @(posedge clk);
    endtask

    initial begin
        logic [3:0]  codes[10];
        logic [32:0] m;
        logic [31:0] ra, rb;
        logic [3:0]  rc;
        bit          seen;

        codes = '{C_ADD, C_SUB, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_SRA, C_OR, C_AND};
        vecs[0]  = '{C_ADD,  32'd7,          32'd5,          32'd12,         1'b0, 1};
        vecs[1]  = '{C_SUB,  32'd9,          32'd9,          32'd0,          1'b1, 1};
        vecs[2]  = '{C_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 5};
        vecs[3]  = '{C_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1};
        vecs[4]  = '{C_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1};
        vecs[5]  = '{C_SLL,  32'h1234_5678,  32'h20,         32'h1234_5678,  1'b0, 1};
        vecs[6]  = '{C_SRL,  32'hF000_0000,  32'h24,         32'h0F00_0000,  1'b0, 5};
        vecs[7]  = '{C_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0, 1};
        vecs[8]  = '{C_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1};
        vecs[9]  = '{C_AND,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0, 1};
        vecs[10] = '{C_SLL,  32'd1,          32'd31,         32'h8000_0000,  1'b0, 32};
        vecs[11] = '{4'b1111, 32'd3,         32'd4,          32'd7,          1'b0, 1};
        vecs[12] = '{C_SUB,  32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        ALUctl = 4'd0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {28'd0, in_ready, out_valid, zero, busy, result},
              {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].z, vecs[i].lat);

        for (int i = 0; i < 16; i++) begin
            rc = codes[$urandom_range(0, 9)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            m = model(rc, ra, rb);
            run_op($sformatf("rand%0d", i), rc, ra, rb, m[31:0], m[32], model_lat(rc, rb, 1));
        end

        run_op4("step4_sra4", C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 2);
        run_op4("step4_sll31", C_SLL, 32'd1, 32'd31, 32'h8000_0000, 1 + 8);
        run_op4("step4_srl5", C_SRL, 32'hFFFF_FFFF, 32'd5, 32'h07FF_FFFF, 1 + 2);

        // Consumer stall: result held, in_ready low, in_valid ignored.
        @(negedge clk);
        out_ready = 1'b0;
        ALUctl = C_ADD; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_first_valid", {63'd0, out_valid}, 64'd1);
        ALUctl = C_SUB; op_a = 32'd10; op_b = 32'd10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", i), {29'd0, out_valid, in_ready, zero, result},
                  {29'd0, 1'b1, 1'b0, 1'b0, 32'd3});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_idle", {62'd0, in_ready, out_valid}, 64'b10);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("stall_single_handshake", {63'd0, seen}, 64'd0);
        check("stall_result_kept", {32'd0, result}, 64'd3);

        // Flush mid-shift.
        @(negedge clk);
        ALUctl = C_SLL; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_idle", {61'd0, in_ready, out_valid, busy}, 64'b100);
        check("flush_result_kept", {31'd0, zero, result}, {31'd0, 1'b0, 32'd3});
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush_no_output", {63'd0, seen}, 64'd0);

        // Flush on the accept edge: op dropped.
        @(negedge clk);
        ALUctl = C_ADD; op_a = 32'd100; op_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_dropped", {62'd0, in_ready, out_valid}, 64'b10);

        // Flush while DONE with out_ready high.
        @(negedge clk);
        ALUctl = C_XOR; op_a = 32'h55; op_b = 32'h0F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_done_valid", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h5A});
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_discard", {62'd0, in_ready, out_valid}, 64'b10);

        // Reset mid-shift.
        @(negedge clk);
        ALUctl = C_SLL; op_a = 32'd1; op_b = 32'd31; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_mid_outputs", {28'd0, in_ready, out_valid, zero, busy, result},
              {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});

        run_op("post_rst_add", C_ADD, 32'd40, 32'd2, 32'd42, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
